// File: rtl/hilo_regfile_pkg.sv
// Shared types and constants for the HI/LO special-register file.
package hilo_regfile_pkg;

   typedef enum logic {
      HILO_IDLE = 1'b0,
      HILO_BUSY = 1'b1
   } hilo_state_e;

   localparam logic RD_SEL_LO = 1'b0;
   localparam logic RD_SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_regfile_if.sv
// Core-side bus of the HI/LO register file: MD results, MTHI/MTLO, MFHI/MFLO reads, status.
interface hilo_regfile_if;
   logic        MD_START;
   logic        MD_DONE;
   logic [31:0] MD_HI_DATA;
   logic [31:0] MD_LO_DATA;
   logic        MTHI;
   logic        MTLO;
   logic [31:0] RS_data;
   logic        RD_REQ;
   logic        RD_SEL;
   logic        RD_READY;
   logic        RD_VALID;
   logic [31:0] RD_DATA;
   logic [31:0] HI_OUT;
   logic [31:0] LO_OUT;
   logic        HILO_BUSY;
   logic        MD_TIMEOUT;

   modport master (
      output MD_START, MD_DONE, MD_HI_DATA, MD_LO_DATA, MTHI, MTLO, RS_data, RD_REQ, RD_SEL,
      input  RD_READY, RD_VALID, RD_DATA, HI_OUT, LO_OUT, HILO_BUSY, MD_TIMEOUT
   );

   modport slave (
      input  MD_START, MD_DONE, MD_HI_DATA, MD_LO_DATA, MTHI, MTLO, RS_data, RD_REQ, RD_SEL,
      output RD_READY, RD_VALID, RD_DATA, HI_OUT, LO_OUT, HILO_BUSY, MD_TIMEOUT
   );
endinterface

// File: rtl/hilo_watchdog.sv
// Busy-cycle counter for an in-flight MULT/DIV; fire_o marks the last allowed BUSY cycle.
module hilo_watchdog #(
   parameter int MAX_BUSY = 64,
   parameter int CNT_W    = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic busy_i,
   input  logic clear_i,
   input  logic done_i,
   output logic fire_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BUSY - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      fire_o = busy_i && !done_i && (cnt_q == LAST);
      if (clear_i || fire_o) begin
         cnt_d = '0;
      end else if (busy_i && !done_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hilo_regfile.sv
// HI/LO register file: tracks one outstanding MULT/DIV, stalls reads while busy, watchdog recovery.
// state     | meaning
// HILO_IDLE | no MULT/DIV in flight; reads accepted
// HILO_BUSY | MULT/DIV in flight; reads stalled, watchdog counting
module hilo_regfile
   import hilo_regfile_pkg::*;
#(
   parameter int MAX_BUSY = 64,
   parameter int CNT_W    = 7
) (
   input  logic           clk,
   input  logic           rst,
   hilo_regfile_if.slave  bus
);

   hilo_state_e state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        hi_disc_q, hi_disc_d, lo_disc_q, lo_disc_d;
   logic        timeout_q, timeout_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_ready, wd_clear, wd_fire;

   hilo_watchdog #(.MAX_BUSY(MAX_BUSY), .CNT_W(CNT_W)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .busy_i  (state_q == HILO_BUSY),
      .clear_i (wd_clear),
      .done_i  (bus.MD_DONE),
      .fire_o  (wd_fire)
   );

   assign rd_ready = (state_q == HILO_IDLE);

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      hi_disc_d  = hi_disc_q;
      lo_disc_d  = lo_disc_q;
      timeout_d  = timeout_q;
      wd_clear   = 1'b0;
      rd_valid_d = bus.RD_REQ && rd_ready;
      rd_data_d  = rd_data_q;

      case (state_q)
         HILO_IDLE: begin
            if (bus.MD_START) begin
               state_d   = HILO_BUSY;
               wd_clear  = 1'b1;
               hi_disc_d = 1'b0;
               lo_disc_d = 1'b0;
            end
         end
         HILO_BUSY: begin
            if (bus.MD_DONE) begin
               if (!hi_disc_q) hi_d = bus.MD_HI_DATA;
               if (!lo_disc_q) lo_d = bus.MD_LO_DATA;
               if (bus.MD_START) begin
                  wd_clear  = 1'b1;
                  hi_disc_d = 1'b0;
                  lo_disc_d = 1'b0;
               end else begin
                  state_d = HILO_IDLE;
               end
            end else if (wd_fire) begin
               state_d   = HILO_IDLE;
               timeout_d = 1'b1;
            end else begin
               hi_disc_d = hi_disc_q || bus.MTHI;
               lo_disc_d = lo_disc_q || bus.MTLO;
            end
         end
         default: state_d = HILO_IDLE;
      endcase

      // Moves from rs override any MD result landing in the same cycle.
      if (bus.MTHI) hi_d = bus.RS_data;
      if (bus.MTLO) lo_d = bus.RS_data;

      if (rd_valid_d) rd_data_d = (bus.RD_SEL == RD_SEL_HI) ? hi_q : lo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HILO_IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         hi_disc_q  <= 1'b0;
         lo_disc_q  <= 1'b0;
         timeout_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         hi_disc_q  <= hi_disc_d;
         lo_disc_q  <= lo_disc_d;
         timeout_q  <= timeout_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.RD_READY   = rd_ready;
   assign bus.RD_VALID   = rd_valid_q;
   assign bus.RD_DATA    = rd_data_q;
   assign bus.HI_OUT     = hi_q;
   assign bus.LO_OUT     = lo_q;
   assign bus.HILO_BUSY  = (state_q == HILO_BUSY);
   assign bus.MD_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_hilo_regfile.sv
// Directed and random checks of hilo_regfile against a cycle-level behavioural model.
module tb_hilo_regfile;

   localparam int MAX_BUSY = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   hilo_regfile_if bus ();

   hilo_regfile #(.MAX_BUSY(MAX_BUSY), .CNT_W(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state
   bit          m_busy, m_hd, m_ld, m_to, m_rdv;
   int          m_cyc;
   logic [31:0] m_hi, m_lo, m_rdd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.MD_START = 0; bus.MD_DONE = 0; bus.MD_HI_DATA = 0; bus.MD_LO_DATA = 0;
      bus.MTHI = 0; bus.MTLO = 0; bus.RS_data = 0; bus.RD_REQ = 0; bus.RD_SEL = 0;
   endtask

   task automatic model_edge();
      logic [31:0] nh, nl;
      bit acc;
      if (rst) begin
         m_busy = 0; m_hd = 0; m_ld = 0; m_to = 0; m_rdv = 0; m_cyc = 0;
         m_hi = 0; m_lo = 0; m_rdd = 0;
         return;
      end
      acc = bus.RD_REQ && !m_busy;
      if (acc) m_rdd = bus.RD_SEL ? m_hi : m_lo;
      m_rdv = acc;
      nh = m_hi; nl = m_lo;
      if (!m_busy) begin
         if (bus.MD_START) begin m_busy = 1; m_cyc = 0; m_hd = 0; m_ld = 0; end
      end else if (bus.MD_DONE) begin
         if (!m_hd) nh = bus.MD_HI_DATA;
         if (!m_ld) nl = bus.MD_LO_DATA;
         if (bus.MD_START) begin m_cyc = 0; m_hd = 0; m_ld = 0; end
         else m_busy = 0;
      end else if (m_cyc == MAX_BUSY - 1) begin
         m_busy = 0; m_to = 1;
      end else begin
         m_cyc++;
         if (bus.MTHI) m_hd = 1;
         if (bus.MTLO) m_ld = 1;
      end
      if (bus.MTHI) nh = bus.RS_data;
      if (bus.MTLO) nl = bus.RS_data;
      m_hi = nh; m_lo = nl;
   endtask

   task automatic step();
      chk("rd_ready", {31'd0, bus.RD_READY}, {31'd0, !m_busy});
      @(posedge clk);
      model_edge();
      #1;
      chk("hi_out",   bus.HI_OUT, m_hi);
      chk("lo_out",   bus.LO_OUT, m_lo);
      chk("busy",     {31'd0, bus.HILO_BUSY}, {31'd0, m_busy});
      chk("timeout",  {31'd0, bus.MD_TIMEOUT}, {31'd0, m_to});
      chk("rd_valid", {31'd0, bus.RD_VALID}, {31'd0, m_rdv});
      chk("rd_data",  bus.RD_DATA, m_rdd);
   endtask

   initial begin
      int busy_cnt;
      clr();
      m_busy = 1; // unknown pre-reset state; RD_READY check skipped below
      rst = 1;
      @(posedge clk); model_edge(); #1;
      step();
      rst = 0;
      chk("reset_hi", bus.HI_OUT, 32'h0);
      chk("reset_ready", {31'd0, bus.RD_READY}, 32'd1);

      // MTHI / MTLO and a HI read
      bus.MTHI = 1; bus.RS_data = 32'h1234_5678; step(); clr();
      chk("mthi", bus.HI_OUT, 32'h1234_5678);
      bus.MTLO = 1; bus.RS_data = 32'hDEAD_BEEF; step(); clr();
      chk("mtlo", bus.LO_OUT, 32'hDEAD_BEEF);
      bus.RD_REQ = 1; bus.RD_SEL = 1; step(); clr();
      chk("rd_hi_valid", {31'd0, bus.RD_VALID}, 32'd1);
      chk("rd_hi_data", bus.RD_DATA, 32'h1234_5678);
      step();
      chk("rd_valid_pulse", {31'd0, bus.RD_VALID}, 32'd0);

      // MULT/DIV with a read held throughout
      busy_cnt = 0;
      bus.RD_REQ = 1; bus.RD_SEL = 0;
      bus.MD_START = 1; step(); bus.MD_START = 0;
      if (bus.HILO_BUSY) busy_cnt++;
      for (int i = 0; i < 5; i++) begin step(); if (bus.HILO_BUSY) busy_cnt++; end
      bus.MD_DONE = 1; bus.MD_HI_DATA = 32'h7; bus.MD_LO_DATA = 32'h3; step();
      bus.MD_DONE = 0;
      chk("busy_cycles", busy_cnt, 6);
      chk("md_hi", bus.HI_OUT, 32'h7);
      step(); clr();
      chk("rd_lo_data", bus.RD_DATA, 32'h3);

      // MTLO during flight discards the LO result
      bus.MD_START = 1; step(); clr();
      step();
      bus.MTLO = 1; bus.RS_data = 32'hAAAA_0000; step(); clr();
      step();
      bus.MD_DONE = 1; bus.MD_HI_DATA = 32'h1; bus.MD_LO_DATA = 32'h2; step(); clr();
      chk("disc_hi", bus.HI_OUT, 32'h1);
      chk("disc_lo", bus.LO_OUT, 32'hAAAA_0000);

      // Back-to-back ops, plus MTHI colliding with MD_DONE
      bus.MD_START = 1; step(); clr(); step();
      bus.MD_DONE = 1; bus.MD_START = 1; bus.MD_HI_DATA = 32'h11; bus.MD_LO_DATA = 32'h22; step(); clr();
      chk("b2b_busy", {31'd0, bus.HILO_BUSY}, 32'd1);
      chk("b2b_lo1", bus.LO_OUT, 32'h22);
      step();
      bus.MD_DONE = 1; bus.MD_HI_DATA = 32'h33; bus.MD_LO_DATA = 32'h44;
      bus.MTHI = 1; bus.RS_data = 32'h5555_5555; step(); clr();
      chk("b2b_hi2", bus.HI_OUT, 32'h5555_5555);
      chk("b2b_lo2", bus.LO_OUT, 32'h44);

      // Watchdog timeout, then stray MD_DONE
      bus.MD_START = 1; step(); clr();
      for (int i = 0; i < MAX_BUSY - 1; i++) step();
      chk("wd_still_busy", {31'd0, bus.HILO_BUSY}, 32'd1);
      step();
      chk("wd_idle", {31'd0, bus.HILO_BUSY}, 32'd0);
      chk("wd_timeout", {31'd0, bus.MD_TIMEOUT}, 32'd1);
      chk("wd_lo_kept", bus.LO_OUT, 32'h44);
      bus.MD_DONE = 1; bus.MD_HI_DATA = 32'hBAD; bus.MD_LO_DATA = 32'hBAD; step(); clr();
      chk("stray_done", bus.HI_OUT, 32'h5555_5555);

      // Reset while busy
      bus.MD_START = 1; step(); clr(); step(); step();
      rst = 1; step(); rst = 0;
      chk("rst_busy", {31'd0, bus.HILO_BUSY}, 32'd0);
      chk("rst_timeout", {31'd0, bus.MD_TIMEOUT}, 32'd0);
      chk("rst_ready", {31'd0, bus.RD_READY}, 32'd1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst             = ($urandom_range(0, 199) == 0);
         bus.MD_START    = ($urandom_range(0, 7) == 0);
         bus.MD_DONE     = ($urandom_range(0, 9) == 0);
         bus.MD_HI_DATA  = $urandom;
         bus.MD_LO_DATA  = $urandom;
         bus.MTHI        = ($urandom_range(0, 9) == 0);
         bus.MTLO        = ($urandom_range(0, 9) == 0);
         bus.RS_data     = $urandom;
         bus.RD_REQ      = ($urandom_range(0, 2) == 0);
         bus.RD_SEL      = 1'($urandom_range(0, 1));
         step();
      end
      rst = 0; clr();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
